dmem_ctrl: RTL



---
 rtl/dmem_ctrl.sv | 121 ++++++++++++
 1 files changed

// File: rtl/dmem_ctrl.sv
`default_nettype none
// ============================================================================
// dmem_ctrl : multi-cycle 256x8 data-memory stage with fixed access latency
//             and pipeline stall for the MIPS_Lite 8-bit datapath.
// Revision   : 1.0 - initial release
// ============================================================================
module dmem_ctrl #(
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] addr,
  input  logic [7:0] wr_data,
  input  logic       mem_read,
  input  logic       mem_write,
  output logic [7:0] rd_data,
  output logic       mem_busy,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] addr_q, addr_d;
  logic [7:0] wdata_q, wdata_d;
  logic       is_write_q, is_write_d;
  logic [7:0] rd_data_q;
  logic       done_q;
  logic       err_q;

  logic [7:0] mem [256];

  logic req_one;
  logic req_both;
  logic last_access;

  assign req_one     = mem_read ^ mem_write;
  assign req_both    = mem_read & mem_write;
  assign last_access = (state_q == ACCESS) && (cnt_q == 4'd0);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    is_write_d = is_write_q;
    mem_busy   = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_one) begin
          mem_busy   = 1'b1;
          addr_d     = addr;
          wdata_d    = wr_data;
          is_write_d = mem_write;
          cnt_d      = CNT_INIT;
          state_d    = ACCESS;
        end
      end
      ACCESS: begin
        mem_busy = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // Requests still asserted here belong to the instruction just served.
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 8'h00;
      wdata_q    <= 8'h00;
      is_write_q <= 1'b0;
      rd_data_q  <= 8'h00;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      is_write_q <= is_write_d;
      done_q     <= last_access;
      err_q      <= (state_q == IDLE) && req_both;
      if (last_access && !is_write_q) begin
        rd_data_q <= mem[addr_q];
      end
    end
  end

  // The store commits only on the final ACCESS edge, so a reset mid-access drops it.
  always_ff @(posedge clk) begin
    if (last_access && is_write_q) begin
      mem[addr_q] <= wdata_q;
    end
  end

  assign rd_data = rd_data_q;
  assign done    = done_q;
  assign err     = err_q;

endmodule
`default_nettype wire
